adpll_lock_monitor: RTL
=======================

Name: adpll_lock_monitor

Overview:
Consumer-side monitor for the ring ADPLL outputs. It runs on the FPGA fabric clock and synchronises the reference clock and the divided generated clock. It samples the signed phase error on every reference edge and measures both clock periods in fabric cycles. A lock state machine turns these into lock, lock-loss and clock-fault status for software and test logic.

Parameters:
PDET_WIDTH, 5, width of signed phase-error input (matches phase detector)
CNT_WIDTH, 16, width of period counters and period outputs
ERR_TOL, 1, max |error_i| counted as an in-tolerance sample
PERIOD_TOL, 2, max |ref_period - gen_period| in fabric cycles counted as in tolerance
LOCK_COUNT, 16, consecutive good samples needed to declare lock (1..255)
UNLOCK_COUNT, 4, consecutive bad samples needed to drop lock (1..255)

Ports:
fpga_clk_i  input  1  fabric clock; all logic is on this clock
reset_n_i  input  1  asynchronous, active-low reset
enable_i  input  1  monitor enable; low forces IDLE
ref_clk_i  input  1  reference clock (asynchronous to fpga_clk_i)
gen_div8_i  input  1  divided generated clock (asynchronous)
error_i  input  PDET_WIDTH  signed phase error from the phase detector
locked_o  output  1  high while in LOCKED
lock_lost_o  output  1  one-cycle pulse on LOCKED->ACQUIRE or LOCKED->FAULT
state_o  output  2  00 IDLE, 01 ACQUIRE, 10 LOCKED, 11 FAULT
ref_period_o  output  CNT_WIDTH  last measured reference period, in fabric cycles
gen_period_o  output  CNT_WIDTH  last measured gen_div8 period, in fabric cycles
loss_count_o  output  8  saturating count of lock losses

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, all counters and synchronisers 0.
- Synchronisation: ref_clk_i and gen_div8_i each pass through 2 flops plus an edge flop. ref_edge and gen_edge are one-cycle pulses on a rising edge. Latency from an input edge to its pulse is 3 cycles.
- Period counters (one per clock):
  - Increment every cycle; saturate at all-ones.
  - On the clock's edge pulse: capture the counter into the period output and reload it to 1.
  - A counter reaching all-ones sets that clock's missing flag. The flag clears on that clock's next edge.
- Sampling: on ref_edge, register error_i.
  - Absolute value is computed in PDET_WIDTH+1 bits, so the most negative code is never in tolerance.
  - good = (|err| <= ERR_TOL) AND (|ref_period_o - gen_period_o| <= PERIOD_TOL). Period outputs are the values before this edge's capture.
  - Any sample that is not good is bad.
- FSM, evaluated every cycle in priority order:
  1. enable_i low: go to IDLE. Clear good_cnt, bad_cnt and the missing flags. Hold period outputs. locked_o drops next cycle.
  2. Either missing flag set while not in IDLE: go to FAULT.
  3. Per-state transitions:
     - IDLE: enable_i high -> ACQUIRE, good_cnt = 0.
     - ACQUIRE: on ref_edge, good increments good_cnt and bad clears it. good_cnt reaching LOCK_COUNT -> LOCKED, bad_cnt = 0.
     - LOCKED: on ref_edge, bad increments bad_cnt and good clears it. bad_cnt reaching UNLOCK_COUNT -> ACQUIRE, good_cnt = 0.
     - FAULT: when both missing flags are clear -> ACQUIRE, good_cnt = 0.
- locked_o and state_o are registered and reflect the state one cycle after the transition.
- Lock loss: on leaving LOCKED for ACQUIRE or FAULT, lock_lost_o pulses for exactly 1 cycle and loss_count_o increments, saturating at 255. Leaving LOCKED because enable_i went low is not a loss.
- Simultaneous events:
  - enable_i low beats everything, including a same-cycle ref_edge.
  - Missing-flag set beats a same-cycle lock decision.
  - A ref_edge and gen_edge in the same cycle are both captured.

Test Plan:
- Reset: hold reset_n_i low with clocks toggling -> all outputs 0. Release, enable_i=1 -> state_o=01 within 1 cycle.
- Acquire: ref and gen both at fabric/20, error_i=0 -> periods read 20. locked_o rises 1 cycle after the 16th good ref_edge. loss_count_o stays 0.
- Error tolerance: while LOCKED, drive error_i=-16 (most negative) for 4 ref edges -> ACQUIRE, lock_lost_o pulses once, loss_count_o=1. Error_i=+1 for 3 edges then 0 -> stays LOCKED.
- Frequency mismatch: gen period 24, ref period 20, error_i=0 -> never leaves ACQUIRE. Gen period 22 -> locks after 16 edges.
- Missing clock: stop gen_div8_i while LOCKED -> FAULT (11) when the gen counter hits 65535, lock_lost_o pulses. Restart it -> ACQUIRE, then LOCKED again.
- Enable and reset priority: drop enable_i in the same cycle as a ref_edge while LOCKED -> IDLE, no lock_lost_o pulse, loss_count_o unchanged. Assert reset_n_i mid-ACQUIRE -> everything 0 immediately.

Source files
------------

// File: rtl/adpll_lock_monitor.sv
// rtl/adpll_lock_monitor.sv - ADPLL lock monitor on the fabric clock
// Synchronises ref/gen clocks, measures their periods and runs the lock FSM.
`timescale 1ns/1ps
module adpll_lock_monitor #(
  parameter int PDET_WIDTH   = 5,
  parameter int CNT_WIDTH    = 16,
  parameter int ERR_TOL      = 1,
  parameter int PERIOD_TOL   = 2,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic                  ref_clk_i,
  input  logic                  gen_div8_i,
  input  logic [PDET_WIDTH-1:0] error_i,
  output logic                  locked_o,
  output logic                  lock_lost_o,
  output logic [1:0]            state_o,
  output logic [CNT_WIDTH-1:0]  ref_period_o,
  output logic [CNT_WIDTH-1:0]  gen_period_o,
  output logic [7:0]            loss_count_o
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_ACQUIRE = 2'b01;
  localparam logic [1:0] S_LOCKED  = 2'b10;
  localparam logic [1:0] S_FAULT   = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]            r_ref_sync;
  logic [1:0]            r_gen_sync;
  logic                  r_ref_last;
  logic                  r_gen_last;
  logic                  r_ref_edge;
  logic                  r_gen_edge;

  logic [CNT_WIDTH-1:0]  r_ref_cnt;
  logic [CNT_WIDTH-1:0]  r_gen_cnt;
  logic [CNT_WIDTH-1:0]  r_ref_period;
  logic [CNT_WIDTH-1:0]  r_gen_period;
  logic                  r_ref_miss;
  logic                  r_gen_miss;

  logic [PDET_WIDTH-1:0] r_err;
  logic                  r_period_ok;
  logic                  r_sample_vld;

  logic [1:0]            r_state;
  logic [7:0]            r_good_cnt;
  logic [7:0]            r_bad_cnt;
  logic                  r_locked;
  logic                  r_lock_lost;
  logic [7:0]            r_loss_cnt;

  logic [CNT_WIDTH:0]    w_pdiff;
  logic [CNT_WIDTH:0]    w_pdiff_abs;
  logic [PDET_WIDTH:0]   w_err_ext;
  logic [PDET_WIDTH:0]   w_err_abs;
  logic                  w_good;
  logic                  w_any_miss;
  logic [7:0]            w_good_inc;
  logic [7:0]            w_bad_inc;
  logic [1:0]            w_state_nxt;
  logic [7:0]            w_good_nxt;
  logic [7:0]            w_bad_nxt;
  logic                  w_lock_lost;
  logic                  w_locked_nxt;

  // Two sync flops, a history flop, then a registered rising-edge pulse.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ref_sync <= 2'b00;
      r_gen_sync <= 2'b00;
      r_ref_last <= 1'b0;
      r_gen_last <= 1'b0;
      r_ref_edge <= 1'b0;
      r_gen_edge <= 1'b0;
    end else begin
      r_ref_sync <= {r_ref_sync[0], ref_clk_i};
      r_gen_sync <= {r_gen_sync[0], gen_div8_i};
      r_ref_last <= r_ref_sync[1];
      r_gen_last <= r_gen_sync[1];
      r_ref_edge <= r_ref_sync[1] & ~r_ref_last;
      r_gen_edge <= r_gen_sync[1] & ~r_gen_last;
    end
  end

  // Period counters keep running while disabled; only the captured outputs hold.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ref_cnt    <= '0;
      r_gen_cnt    <= '0;
      r_ref_period <= '0;
      r_gen_period <= '0;
      r_ref_miss   <= 1'b0;
      r_gen_miss   <= 1'b0;
    end else begin
      if (r_ref_edge) begin
        r_ref_cnt <= CNT_ONE;
        if (enable_i) r_ref_period <= r_ref_cnt;
      end else if (r_ref_cnt != CNT_MAX) begin
        r_ref_cnt <= r_ref_cnt + CNT_ONE;
      end

      if (r_gen_edge) begin
        r_gen_cnt <= CNT_ONE;
        if (enable_i) r_gen_period <= r_gen_cnt;
      end else if (r_gen_cnt != CNT_MAX) begin
        r_gen_cnt <= r_gen_cnt + CNT_ONE;
      end

      if (!enable_i || r_ref_edge)   r_ref_miss <= 1'b0;
      else if (r_ref_cnt == CNT_MAX) r_ref_miss <= 1'b1;

      if (!enable_i || r_gen_edge)   r_gen_miss <= 1'b0;
      else if (r_gen_cnt == CNT_MAX) r_gen_miss <= 1'b1;
    end
  end

  // Period match uses the outputs as they stood before this edge's capture.
  assign w_pdiff     = {1'b0, r_ref_period} - {1'b0, r_gen_period};
  assign w_pdiff_abs = w_pdiff[CNT_WIDTH] ? (~w_pdiff + 1'b1) : w_pdiff;

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err        <= '0;
      r_period_ok  <= 1'b0;
      r_sample_vld <= 1'b0;
    end else begin
      r_sample_vld <= r_ref_edge & enable_i;
      if (r_ref_edge) begin
        r_err       <= error_i;
        r_period_ok <= (w_pdiff_abs <= (CNT_WIDTH+1)'(PERIOD_TOL));
      end
    end
  end

  // One extra bit keeps the most negative code's magnitude out of tolerance.
  assign w_err_ext  = {r_err[PDET_WIDTH-1], r_err};
  assign w_err_abs  = w_err_ext[PDET_WIDTH] ? (~w_err_ext + 1'b1) : w_err_ext;
  assign w_good     = (w_err_abs <= (PDET_WIDTH+1)'(ERR_TOL)) && r_period_ok;
  assign w_any_miss = r_ref_miss | r_gen_miss;
  assign w_good_inc = r_good_cnt + 8'd1;
  assign w_bad_inc  = r_bad_cnt + 8'd1;

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_good_cnt  <= 8'd0;
      r_bad_cnt   <= 8'd0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
      r_loss_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_good_cnt  <= w_good_nxt;
      r_bad_cnt   <= w_bad_nxt;
      r_locked    <= w_locked_nxt;
      r_lock_lost <= w_lock_lost;
      if (w_lock_lost && (r_loss_cnt != 8'hFF)) r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    if (!enable_i) begin
      w_state_nxt = S_IDLE;
      w_good_nxt  = 8'd0;
      w_bad_nxt   = 8'd0;
    end else if (w_any_miss && (r_state != S_IDLE)) begin
      w_state_nxt = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ACQUIRE;
          w_good_nxt  = 8'd0;
        end
        S_ACQUIRE: begin
          if (r_sample_vld) begin
            if (w_good) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc == 8'(LOCK_COUNT)) begin
                w_state_nxt = S_LOCKED;
                w_bad_nxt   = 8'd0;
              end
            end else begin
              w_good_nxt = 8'd0;
            end
          end
        end
        S_LOCKED: begin
          if (r_sample_vld) begin
            if (!w_good) begin
              w_bad_nxt = w_bad_inc;
              if (w_bad_inc == 8'(UNLOCK_COUNT)) begin
                w_state_nxt = S_ACQUIRE;
                w_good_nxt  = 8'd0;
              end
            end else begin
              w_bad_nxt = 8'd0;
            end
          end
        end
        default: begin
          if (!w_any_miss) begin
            w_state_nxt = S_ACQUIRE;
            w_good_nxt  = 8'd0;
          end
        end
      endcase
    end
  end

  // Disabling the monitor is never counted as a lock loss.
  always_comb begin
    w_locked_nxt = (w_state_nxt == S_LOCKED);
    w_lock_lost  = enable_i && (r_state == S_LOCKED) && (w_state_nxt != S_LOCKED);
  end

  assign locked_o     = r_locked;
  assign lock_lost_o  = r_lock_lost;
  assign state_o      = r_state;
  assign ref_period_o = r_ref_period;
  assign gen_period_o = r_gen_period;
  assign loss_count_o = r_loss_cnt;

endmodule
